// File: rtl/r5p_wbq_pkg.sv
// Shared types and constants for the R5P in-order write-back queue.
package r5p_wbq_pkg;

    localparam int WBQ_SW = 4;

    typedef logic [WBQ_SW-1:0] wbq_src_t;

    localparam wbq_src_t WBQ_SRC_NONE = 4'd0;
    localparam wbq_src_t WBQ_SRC_ALU  = 4'd1;
    localparam wbq_src_t WBQ_SRC_LSU  = 4'd2;
    localparam wbq_src_t WBQ_SRC_MUL  = 4'd3;
    localparam wbq_src_t WBQ_SRC_CSR  = 4'd4;

    typedef struct packed {
        logic       wen;
        logic [4:0] adr;
        wbq_src_t   src;
    } wbq_ent_t;

    // One-hot GPR decode; x0 never reports as pending.
    function automatic logic [31:0] wbq_rd_dec(input logic [4:0] adr);
        return (adr == 5'd0) ? 32'd0 : (32'd1 << adr);
    endfunction

endpackage

// File: rtl/r5p_wbq_if.sv
// Issue, result-channel and GPR write-port bundle of the write-back queue.
interface r5p_wbq_if #(
    parameter int XLEN = 32,
    parameter int NSRC = 4
);
    localparam int SW = $clog2(NSRC + 1);

    logic                      flush;
    logic                      iss_vld;
    logic                      iss_rdy;
    logic                      iss_wen;
    logic [4:0]                iss_adr;
    logic [SW-1:0]             iss_src;
    logic [NSRC-1:0]           res_vld;
    logic [NSRC-1:0]           res_rdy;
    logic [NSRC-1:0][XLEN-1:0] res_dat;
    logic                      wen;
    logic [4:0]                adr;
    logic [XLEN-1:0]           dat;
    logic [31:0]               busy;
    logic                      empty;

    modport master (
        output flush, iss_vld, iss_wen, iss_adr, iss_src, res_vld, res_dat,
        input  iss_rdy, res_rdy, wen, adr, dat, busy, empty
    );

    modport slave (
        input  flush, iss_vld, iss_wen, iss_adr, iss_src, res_vld, res_dat,
        output iss_rdy, res_rdy, wen, adr, dat, busy, empty
    );

endinterface

// File: rtl/r5p_wbq_chk.sv
// Protocol checker: issuing with a source channel beyond NSRC is illegal.
module r5p_wbq_chk #(
    parameter int NSRC = 4,
    parameter int SW   = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          iss_vld,
    input logic          iss_rdy,
    input logic [SW-1:0] iss_src
);
    a_src_legal: assert property (@(posedge clk) disable iff (rst)
        (iss_vld && iss_rdy) |-> (iss_src <= SW'(NSRC)));
endmodule

// File: rtl/r5p_wbq_fifo.sv
// Pointer FIFO with wrap-bit full/empty detection and a flat view of all
// entries plus per-slot valid flags for the scoreboard.
import r5p_wbq_pkg::*;

module r5p_wbq_fifo #(
    parameter int  DEPTH = 4,
    parameter type ent_t = wbq_ent_t
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    clr,
    input  logic                                    push,
    input  ent_t                                    din,
    input  logic                                    pop,
    output logic                                    full,
    output logic                                    empty,
    output ent_t                                    head,
    output logic [DEPTH-1:0][$bits(ent_t)-1:0]      ent,
    output logic [DEPTH-1:0]                        vld
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] cnt_s;
    logic [AW-1:0] off_s;
    ent_t        mem_r [DEPTH];

    assign cnt_s = wr_ptr_r - rd_ptr_r;
    assign full  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign head  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; clr rewinds both pointers to slot 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Entry storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (push && !clr) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Slot i is live when its distance from the read index is below the count
    always_comb begin
        off_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off_s  = AW'(i) - rd_ptr_r[AW-1:0];
            vld[i] = ({1'b0, off_s} < cnt_s);
            ent[i] = mem_r[i];
        end
    end

endmodule

// File: rtl/r5p_wbq.sv
// R5P in-order write-back queue: accepts results from NSRC channels strictly in
// issue order and drives a registered GPR write port. R5P_WBQ_SCOREBOARD_EN builds busy.
import r5p_wbq_pkg::*;

module r5p_wbq #(
    parameter int XLEN  = 32,
    parameter int NSRC  = 4,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    r5p_wbq_if.slave   bus
);
    localparam int SW = $clog2(NSRC + 1);

    logic                                   fifo_full_s;
    logic                                   fifo_empty_s;
    wbq_ent_t                               head_s;
    logic [DEPTH-1:0][$bits(wbq_ent_t)-1:0] ent_s;
    logic [DEPTH-1:0]                       vld_s;
    wbq_ent_t                               din_s;
    logic                                   iss_rdy_s;
    logic                                   push_s;
    logic                                   head_ok_s;
    logic                                   retire_s;
    logic [NSRC-1:0]                        res_rdy_s;
    logic [XLEN-1:0]                        sel_dat_s;
    logic [31:0]                            busy_s;
    logic                                   wen_r;
    logic [4:0]                             adr_r;
    logic [XLEN-1:0]                        dat_r;

    assign iss_rdy_s = !fifo_full_s && !bus.flush;
    assign push_s    = bus.iss_vld && iss_rdy_s;
    assign head_ok_s = !fifo_empty_s && !bus.flush;

    // Out-of-range sources are stored as "no result" so the head never deadlocks
    always_comb begin
        din_s     = '0;
        din_s.wen = bus.iss_wen;
        din_s.adr = bus.iss_adr;
        din_s.src = (bus.iss_src > SW'(NSRC)) ? WBQ_SRC_NONE : WBQ_SW'(bus.iss_src);
    end

    r5p_wbq_fifo #(.DEPTH(DEPTH), .ent_t(wbq_ent_t)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.flush),
        .push  (push_s),
        .din   (din_s),
        .pop   (retire_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (head_s),
        .ent   (ent_s),
        .vld   (vld_s)
    );

    // Only the head's channel is offered ready; one-hot so the data mux is an OR
    always_comb begin
        res_rdy_s = '0;
        sel_dat_s = {XLEN{1'b0}};
        for (int k = 0; k < NSRC; k++) begin
            res_rdy_s[k] = head_ok_s && (head_s.src == WBQ_SW'(k + 1));
            sel_dat_s    = sel_dat_s | ({XLEN{res_rdy_s[k]}} & bus.res_dat[k]);
        end
        retire_s = head_ok_s &&
                   ((head_s.src == WBQ_SRC_NONE) || ((res_rdy_s & bus.res_vld) != {NSRC{1'b0}}));
    end

    // GPR write port; a write already registered completes even across a flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_r <= 1'b0;
            adr_r <= 5'd0;
            dat_r <= {XLEN{1'b0}};
        end else if (bus.flush) begin
            wen_r <= 1'b0;
        end else if (retire_s) begin
            wen_r <= head_s.wen && (head_s.adr != 5'd0);
            adr_r <= head_s.adr;
            dat_r <= sel_dat_s;
        end else begin
            wen_r <= 1'b0;
        end
    end

`ifdef R5P_WBQ_SCOREBOARD_EN
    // Pending-rd bitmap from queued writers plus the output stage
    always_comb begin
        busy_s = wen_r ? wbq_rd_dec(adr_r) : 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_s = busy_s | ((vld_s[i] && ent_s[i][$bits(wbq_ent_t)-1])
                               ? wbq_rd_dec(ent_s[i][$bits(wbq_ent_t)-2 -: 5]) : 32'd0);
        end
    end
`else
    logic unused_sb_s;
    assign unused_sb_s = ^{ent_s, vld_s};
    assign busy_s      = 32'd0;
`endif

    assign bus.iss_rdy = iss_rdy_s;
    assign bus.res_rdy = res_rdy_s;
    assign bus.wen     = wen_r;
    assign bus.adr     = adr_r;
    assign bus.dat     = dat_r;
    assign bus.busy    = busy_s;
    assign bus.empty   = fifo_empty_s && !wen_r;

    r5p_wbq_chk #(.NSRC(NSRC), .SW(SW)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .iss_vld (bus.iss_vld),
        .iss_rdy (iss_rdy_s),
        .iss_src (bus.iss_src)
    );

endmodule
